hidden_layer_seq: RTL and testbench
===================================

# hidden_layer_seq

Sequential hidden-layer engine for the tiny MLP datapath. It latches one input vector and computes `N_HID` neurons with a single shared 8x8 signed MAC. Weights and biases arrive on a valid/ready byte stream. Each neuron gets ReLU + shift/clip, and the results are packed into the 80-bit `outreg` bus consumed by the output neuron stage.

## Interface
- `N_IN`, default 8: inputs per neuron.
- `N_HID`, default 10: hidden neurons, so `outreg` is `N_HID*8` bits.
- `ACC_W`, default 24: accumulator width.
- `SHIFT`, default 0: arithmetic right shift applied before clipping.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a pass; honoured only when not busy.
- `x_in`, in, `N_IN*8`: signed input bytes, element i at `[8i+:8]`; sampled on accepted `start`.
- `p_data`, in, 8: signed parameter byte.
- `p_valid`, in, 1: `p_data` valid.
- `p_ready`, out, 1: engine accepts `p_data` this cycle.
- `outreg`, out, `N_HID*8`: neuron j result at `[8j+:8]`.
- `out_valid`, out, 1: level; all bytes of `outreg` are from the latest completed pass.
- `busy`, out, 1: pass in progress.

## Operation
- FSM states: IDLE, MAC, BIAS, ACT, DONE.
- IDLE/DONE + `start`:
  - latch `x_in`, clear `acc`, set neuron idx j=0 and beat idx i=0;
  - go to MAC; `out_valid` drops.
- Parameter stream order: for j = 0..N_HID-1, send w[j][0..N_IN-1], then bias b[j]. Total `N_HID*(N_IN+1)` beats (90 at defaults).
- A beat transfers when `p_valid & p_ready`.
- MAC (`p_ready`=1): on a beat, `acc <= acc + sext(x[i]*p_data)`, where the product is 16-bit signed. i increments; after beat `N_IN-1`, go to BIAS.
- BIAS (`p_ready`=1): on a beat, `acc <= acc + sext(p_data)`, with the bias unscaled. Go to ACT.
- ACT (`p_ready`=0), one cycle:
  - byte r = 0 if `acc` < 0; otherwise r = clip(`acc >>> SHIFT`);
  - write `outreg[8j+:8] <= r`; clear `acc`;
  - if j = N_HID-1, go to DONE; else j++, i=0, go to MAC.
- DONE: `out_valid`=1, `busy`=0, `outreg` held stable until the next accepted `start`.
- Arithmetic: two's complement. `acc` wraps at `ACC_W` bits, with no overflow flag; defaults cannot overflow (max |acc| = 8·128·128+128).
- `start` while busy: ignored.
- `p_valid` low: the FSM stalls in MAC/BIAS indefinitely; there is no timeout.
- A new pass rewrites `outreg` bytes one at a time. Bytes not yet rewritten keep the previous pass's values; `out_valid`=0 marks them stale.

## Timing
- Reset values: `outreg`=0, `out_valid`=0, `p_ready`=0, `busy`=0, `acc`=0, state IDLE.
- `rst` mid-pass: the next cycle is IDLE with all reset values. Any partial stream is discarded; upstream must restart the stream from beat 0.
- With `start` accepted at edge 0 and `p_valid` held high:
  - neuron j ACT occurs at cycle `(N_IN+2)(j+1)`;
  - `out_valid` rises at cycle `(N_IN+2)·N_HID + 1` (101 at defaults).
- Each cycle with `p_ready`=1 and `p_valid`=0 adds exactly one cycle of latency.
- `busy` = state ∈ {MAC, BIAS, ACT}.
- `p_ready` is registered from state only; it has no combinational dependence on `p_valid`.

## Configuration
- `HIDDEN_LAYER_SAT_EN` defined: clip saturates, r = min(`acc >>> SHIFT`, 127), so outputs are 0..127.
- Undefined: r = `(acc >>> SHIFT)[7:0]` (raw truncation, wraps; may read negative downstream). This saves the comparator.

## Structure
- Shared package `nn_pkg`:
  - `DATA_W` = 8, `ACC_W` default, `N_HID` default;
  - `hl_state_t` enum for the five states.
- Sub-module `relu_clip`: combinational, `acc` in → 8-bit byte out. Contains the ReLU, the shift, and the `HIDDEN_LAYER_SAT_EN` branch.

## Test plan
- Reset: `rst` high for 2 cycles → `outreg`=0, `out_valid`=0, `p_ready`=0, `busy`=0.
- Baseline: x all 1, all weights 1, all biases 0, `p_valid` constant high → `outreg` = ten bytes of 0x08; `out_valid` rises at cycle 101.
- ReLU: same as baseline, but neuron 3 weights = -1 and b[3] = 2 → byte 3 = 0x00, other bytes 0x08.
- Clip: x=127, w=127, b=127 (acc=129159) → every byte 0x7F with `HIDDEN_LAYER_SAT_EN`, 0x87 without.
- Backpressure: baseline data with `p_valid` toggled every cycle → identical `outreg`; `out_valid` delay increases by exactly the number of idle `p_ready` cycles. A `start` pulse at cycle 30 is ignored.
- Mid-pass reset: `rst` at cycle 50 → IDLE and zeros next cycle. A fresh `start` plus full stream then yields the baseline result at cycle +101.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the tiny MLP datapath: data/accumulator widths,
// default layer sizes and the hidden-layer sequencer state encoding.
package nn_pkg;

    localparam int DATA_W    = 8;
    localparam int ACC_W_DEF = 24;
    localparam int N_HID_DEF = 10;
    localparam int N_IN_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_BIAS,
        ST_ACT,
        ST_DONE
    } hl_state_t;

    function automatic logic state_busy(hl_state_t s);
        return (s == ST_MAC) || (s == ST_BIAS) || (s == ST_ACT);
    endfunction

    function automatic logic state_ready(hl_state_t s);
        return (s == ST_MAC) || (s == ST_BIAS);
    endfunction

endpackage

// File: rtl/hidden_layer_seq_if.sv
// Control, input-vector, parameter-stream and result signals of the
// hidden-layer engine; master = upstream/consumer side, slave = engine.
interface hidden_layer_seq_if #(
    parameter int N_IN  = 8,
    parameter int N_HID = 10
);
    logic                  start;
    logic [N_IN*8-1:0]     x_in;
    logic [7:0]            p_data;
    logic                  p_valid;
    logic                  p_ready;
    logic [N_HID*8-1:0]    outreg;
    logic                  out_valid;
    logic                  busy;

    modport master (
        output start, x_in, p_data, p_valid,
        input  p_ready, outreg, out_valid, busy
    );

    modport slave (
        input  start, x_in, p_data, p_valid,
        output p_ready, outreg, out_valid, busy
    );

endinterface

// File: rtl/hidden_layer_seq_relu_clip.sv
// ReLU, arithmetic shift and byte clip of one neuron accumulator.
// HIDDEN_LAYER_SAT_EN selects saturation to 127; otherwise the low byte wraps.
module relu_clip #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [7:0]       r
);
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        r       = '0;
        if (!acc[ACC_W-1]) begin
`ifdef HIDDEN_LAYER_SAT_EN
            if (shifted > ACC_W'(127)) begin
                r = 8'd127;
            end else begin
                r = 8'(shifted);
            end
`else
            r = 8'(shifted);
`endif
        end
    end

endmodule

// File: rtl/hidden_layer_seq.sv
// Sequential hidden layer: one shared 8x8 signed MAC walks N_HID neurons over
// a valid/ready weight+bias byte stream. Optional macro: HIDDEN_LAYER_SAT_EN.
module hidden_layer_seq #(
    parameter int N_IN  = nn_pkg::N_IN_DEF,
    parameter int N_HID = nn_pkg::N_HID_DEF,
    parameter int ACC_W = nn_pkg::ACC_W_DEF,
    parameter int SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    hidden_layer_seq_if.slave  bus
);
    import nn_pkg::*;

    localparam int I_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int J_W = (N_HID > 1) ? $clog2(N_HID) : 1;

    hl_state_t state, next_state;

    logic [N_IN*DATA_W-1:0]   x_lat;
    logic [I_W-1:0]           i_idx;
    logic [J_W-1:0]           j_idx;
    logic signed [ACC_W-1:0]  acc;
    logic [N_HID*DATA_W-1:0]  outreg_q;
    logic                     p_ready_q;
    logic                     busy_q;
    logic                     out_valid_q;

    logic                     beat;
    logic                     last_i;
    logic                     last_j;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [DATA_W-1:0] p_s;
    logic signed [15:0]       prod;
    logic [7:0]               r;

    assign beat   = bus.p_valid & p_ready_q;
    assign last_i = (i_idx == I_W'(N_IN - 1));
    assign last_j = (j_idx == J_W'(N_HID - 1));
    assign p_s    = bus.p_data;

    always_comb begin
        x_cur = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (i_idx == I_W'(k)) begin
                x_cur = x_lat[8*k +: 8];
            end
        end
    end

    assign prod = x_cur * p_s;

    relu_clip #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_relu_clip (
        .acc (acc),
        .r   (r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start) next_state = ST_MAC;
            ST_MAC:           if (beat && last_i) next_state = ST_BIAS;
            ST_BIAS:          if (beat) next_state = ST_ACT;
            ST_ACT:           next_state = last_j ? ST_DONE : ST_MAC;
            default:          next_state = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from next_state into flops so they are
    // pure state registers that change together with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p_ready_q   <= state_ready(next_state);
            busy_q      <= state_busy(next_state);
            out_valid_q <= (next_state == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat    <= '0;
            acc      <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            outreg_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        x_lat <= bus.x_in;
                        acc   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                    end
                end
                ST_MAC: begin
                    if (beat) begin
                        acc   <= acc + ACC_W'(prod);
                        i_idx <= last_i ? '0 : i_idx + I_W'(1);
                    end
                end
                ST_BIAS: begin
                    if (beat) begin
                        acc <= acc + ACC_W'(p_s);
                    end
                end
                ST_ACT: begin
                    for (int unsigned k = 0; k < N_HID; k++) begin
                        if (j_idx == J_W'(k)) begin
                            outreg_q[8*k +: 8] <= r;
                        end
                    end
                    acc   <= '0;
                    i_idx <= '0;
                    if (!last_j) begin
                        j_idx <= j_idx + J_W'(1);
                    end
                end
                default: begin
                    acc <= '0;
                end
            endcase
        end
    end

    assign bus.p_ready   = p_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.outreg    = outreg_q;

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed self-checking bench for hidden_layer_seq at default parameters;
// clip expectations follow HIDDEN_LAYER_SAT_EN.
module tb_hidden_layer_seq;

    localparam int NB = 90;

    logic clk;
    logic rst;

    hidden_layer_seq_if #(.N_IN(8), .N_HID(10)) bus ();

    hidden_layer_seq #(
        .N_IN  (8),
        .N_HID (10),
        .ACC_W (24),
        .SHIFT (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [7:0]  strm [NB];
    logic [79:0] base_exp;

    // Observations captured by run_pass at fixed edges after the start edge.
    logic        ov_after_start;
    logic        ready_at_act;
    logic        busy_at_act;
    logic        busy_at_31;
    logic [79:0] out_at_5;

    task automatic build_stream(input logic [7:0] w, input logic [7:0] b);
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 8; k++) strm[j*9 + k] = w;
            strm[j*9 + 8] = b;
        end
    endtask

    // Edge 0 accepts start; edges counts edges after it until out_valid is
    // seen (or stop_at is reached). toggle: p_valid high only on odd edges.
    task automatic run_pass(input logic [63:0] x, input bit toggle,
                            input bit poke_start, input int stop_at,
                            output int edges, output logic [79:0] res);
        int  beat;
        bit  fire;
        bus.x_in    = x;
        bus.start   = 1'b1;
        bus.p_valid = 1'b0;
        bus.p_data  = '0;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        ov_after_start = bus.out_valid;
        beat  = 0;
        edges = 0;
        while (!bus.out_valid && edges < stop_at) begin
            bus.p_valid = (beat < NB) && (!toggle || ((edges + 1) % 2 == 1));
            bus.p_data  = (beat < NB) ? strm[beat] : 8'h00;
            bus.start   = poke_start && (edges + 1 == 30);
            if (bus.start) bus.x_in = {8{8'h05}};
            fire = bus.p_valid && bus.p_ready;
            @(posedge clk); #1;
            edges++;
            if (fire) beat++;
            if (edges == 5) out_at_5 = bus.outreg;
            if (edges == 9) begin
                ready_at_act = bus.p_ready;
                busy_at_act  = bus.busy;
            end
            if (edges == 31) busy_at_31 = bus.busy;
        end
        bus.p_valid = 1'b0;
        bus.start   = 1'b0;
        res = bus.outreg;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (bus.outreg !== 80'h0) begin
            miscompares++; $display("FAIL reset_outreg: got %h expected %h", bus.outreg, 80'h0);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        vectors++;
        if (bus.p_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_p_ready: got %b expected 0", bus.p_ready);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_baseline();
        int          n;
        logic [79:0] res;
        build_stream(8'h01, 8'h00);
        run_pass({8{8'h01}}, 1'b0, 1'b0, 1000, n, res);
        vectors++;
        if (res !== base_exp) begin
            miscompares++; $display("FAIL baseline_outreg: got %h expected %h", res, base_exp);
        end
        vectors++;
        if (n + 1 !== 101) begin
            miscompares++; $display("FAIL baseline_valid_cycle: got %0d expected 101", n + 1);
        end
        vectors++;
        if (ready_at_act !== 1'b0 || busy_at_act !== 1'b1) begin
            miscompares++;
            $display("FAIL baseline_act_flags: got ready=%b busy=%b expected ready=0 busy=1",
                     ready_at_act, busy_at_act);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL baseline_done_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back_relu();
        int          n;
        logic [79:0] res;
        logic [79:0] exp;
        build_stream(8'h01, 8'h00);
        for (int k = 0; k < 8; k++) strm[27 + k] = 8'hFF;
        strm[35] = 8'h02;
        exp = base_exp;
        exp[31:24] = 8'h00;
        run_pass({8{8'h01}}, 1'b0, 1'b0, 1000, n, res);
        vectors++;
        if (ov_after_start !== 1'b0) begin
            miscompares++; $display("FAIL b2b_out_valid_drop: got %b expected 0", ov_after_start);
        end
        vectors++;
        if (out_at_5 !== base_exp) begin
            miscompares++; $display("FAIL b2b_stale_bytes: got %h expected %h", out_at_5, base_exp);
        end
        vectors++;
        if (res !== exp) begin
            miscompares++; $display("FAIL relu_outreg: got %h expected %h", res, exp);
        end
    endtask

    task automatic test_clip();
        int          n;
        logic [79:0] res;
        logic [79:0] exp;
`ifdef HIDDEN_LAYER_SAT_EN
        exp = {10{8'h7F}};
`else
        exp = {10{8'h87}};
`endif
        build_stream(8'h7F, 8'h7F);
        run_pass({8{8'h7F}}, 1'b0, 1'b0, 1000, n, res);
        vectors++;
        if (res !== exp) begin
            miscompares++; $display("FAIL clip_outreg: got %h expected %h", res, exp);
        end
    endtask

    task automatic test_backpressure();
        int          n;
        logic [79:0] res;
        build_stream(8'h01, 8'h00);
        run_pass({8{8'h01}}, 1'b1, 1'b1, 1000, n, res);
        vectors++;
        if (res !== base_exp) begin
            miscompares++; $display("FAIL bp_outreg: got %h expected %h", res, base_exp);
        end
        // 8 idle p_ready cycles per neuron -> 100 + 80 edges
        vectors++;
        if (n !== 180) begin
            miscompares++; $display("FAIL bp_valid_edge: got %0d expected 180", n);
        end
        vectors++;
        if (busy_at_31 !== 1'b1) begin
            miscompares++; $display("FAIL bp_start_ignored_busy: got %b expected 1", busy_at_31);
        end
    endtask

    task automatic test_midpass_reset();
        int          n;
        logic [79:0] res;
        build_stream(8'h01, 8'h00);
        run_pass({8{8'h01}}, 1'b0, 1'b0, 49, n, res);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (bus.outreg !== 80'h0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got outreg=%h valid=%b expected 0/0", bus.outreg, bus.out_valid);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.p_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_flags: got busy=%b ready=%b expected 0/0", bus.busy, bus.p_ready);
        end
        @(posedge clk); #1;
        run_pass({8{8'h01}}, 1'b0, 1'b0, 1000, n, res);
        vectors++;
        if (res !== base_exp) begin
            miscompares++; $display("FAIL midrst_rerun_outreg: got %h expected %h", res, base_exp);
        end
        vectors++;
        if (n + 1 !== 101) begin
            miscompares++; $display("FAIL midrst_rerun_cycle: got %0d expected 101", n + 1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        base_exp    = {10{8'h08}};
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.x_in    = '0;
        bus.p_data  = '0;
        bus.p_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_baseline();
        test_back_to_back_relu();
        test_clip();
        test_backpressure();
        test_midpass_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
